bullcow_entry: RTL and testbench

//  Player-side number entry for the Bulls & Cows game: producer end of the game's 4-digit number interface.

---
 rtl/bullcow_entry.sv | 107 ++++++++++
 tb/tb_bullcow_entry.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bullcow_entry.sv
// Player digit entry for Bulls & Cows: collects digits, checks them, offers the number on valid/ready.
// Latency: last digit strobe at cycle N -> number_valid at N+2. Backpressure: the offer holds until number_ready.
// Optional backspace input del_stb when BULLCOW_ENTRY_BACKSPACE_EN is defined.
module bullcow_entry #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_MAX  = 9,
  parameter bit UNIQUE     = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [3:0]                  digit_in,
  input  logic                        digit_stb,
  input  logic                        clear_stb,
`ifdef BULLCOW_ENTRY_BACKSPACE_EN
  input  logic                        del_stb,
`endif
  output logic [NUM_DIGITS-1:0][3:0]  number_out,
  output logic                        number_valid,
  input  logic                        number_ready,
  output logic                        reject,
  output logic [2:0]                  digit_count
);

  typedef enum logic [1:0] {COLLECT, CHECK, OFFER} state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  state_t                       state;
  logic [NUM_DIGITS-1:0][3:0]   num_buf;
  logic                         dup;
  logic                         digit_ok;
  logic                         del_req;

`ifdef BULLCOW_ENTRY_BACKSPACE_EN
  assign del_req = del_stb;
`else
  assign del_req = 1'b0;
`endif

  assign digit_ok   = (digit_in <= 4'(DIGIT_MAX));
  assign number_out = num_buf;

  // Duplicate search works only on the registered buffer, so it is stable throughout CHECK.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        if (num_buf[i] == num_buf[j]) dup = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= COLLECT;
      num_buf      <= '0;
      number_valid <= 1'b0;
      reject       <= 1'b0;
      digit_count  <= 3'd0;
    end else begin
      reject <= 1'b0;
      case (state)
        COLLECT: begin
          if (clear_stb) begin
            num_buf     <= '0;
            digit_count <= 3'd0;
          end else if (del_req) begin
            if (digit_count != 3'd0) begin
              num_buf     <= {4'h0, num_buf[NUM_DIGITS-1:1]};
              digit_count <= digit_count - 3'd1;
            end
          end else if (digit_stb) begin
            if (digit_ok) begin
              num_buf     <= {num_buf[NUM_DIGITS-2:0], digit_in};
              digit_count <= digit_count + 3'd1;
              if (digit_count == LAST_IDX) state <= CHECK;
            end else begin
              reject <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (UNIQUE && dup) begin
            reject      <= 1'b1;
            num_buf     <= '0;
            digit_count <= 3'd0;
            state       <= COLLECT;
          end else begin
            number_valid <= 1'b1;
            state        <= OFFER;
          end
        end
        OFFER: begin
          // The offer is never withdrawn; only a transfer leaves this state.
          if (number_ready) begin
            number_valid <= 1'b0;
            num_buf      <= '0;
            digit_count  <= 3'd0;
            state        <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_bullcow_entry.sv
// Directed bench for bullcow_entry: a UNIQUE=1 and a UNIQUE=0 instance share all stimulus.
module tb_bullcow_entry;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [3:0]       digit_in = 4'h0;
  logic             digit_stb = 1'b0;
  logic             clear_stb = 1'b0;
  logic             del_stb = 1'b0;
  logic             number_ready = 1'b0;
  logic [3:0][3:0]  number_out, nu_out;
  logic             number_valid, nu_valid;
  logic             reject, nu_reject;
  logic [2:0]       digit_count, nu_count;

  int total = 0;
  int bad   = 0;
  int xfers = 0;
  int x0;

  always #5 clock = ~clock;

  bullcow_entry #(.NUM_DIGITS(4), .DIGIT_MAX(9), .UNIQUE(1'b1)) dut (
    .clock(clock), .reset(reset), .digit_in(digit_in), .digit_stb(digit_stb),
    .clear_stb(clear_stb),
`ifdef BULLCOW_ENTRY_BACKSPACE_EN
    .del_stb(del_stb),
`endif
    .number_out(number_out), .number_valid(number_valid), .number_ready(number_ready),
    .reject(reject), .digit_count(digit_count)
  );

  bullcow_entry #(.NUM_DIGITS(4), .DIGIT_MAX(9), .UNIQUE(1'b0)) dut_nu (
    .clock(clock), .reset(reset), .digit_in(digit_in), .digit_stb(digit_stb),
    .clear_stb(clear_stb),
`ifdef BULLCOW_ENTRY_BACKSPACE_EN
    .del_stb(del_stb),
`endif
    .number_out(nu_out), .number_valid(nu_valid), .number_ready(number_ready),
    .reject(nu_reject), .digit_count(nu_count)
  );

  always @(posedge clock) if (reset && number_valid && number_ready) xfers++;

  typedef struct {
    logic [15:0] digits;
    logic        ok;
  } vec_t;

  vec_t vec [6];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Strobe one digit for exactly one rising edge; returns in the following cycle.
  task automatic put(input logic [3:0] d);
    digit_in  = d;
    digit_stb = 1'b1;
    @(negedge clock);
    digit_stb = 1'b0;
  endtask

  initial begin
    vec[0] = '{16'h1234, 1'b1};
    vec[1] = '{16'h5057, 1'b0};
    vec[2] = '{16'h9876, 1'b1};
    vec[3] = '{16'h0000, 1'b0};
    vec[4] = '{16'h1231, 1'b0};
    vec[5] = '{16'h0987, 1'b1};

    #2;
    chk("rst_valid", 16'(number_valid), 16'h0);
    chk("rst_num",   16'(number_out),   16'h0);
    chk("rst_count", 16'(digit_count),  16'h0);
    chk("rst_reject",16'(reject),       16'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Table: four digits with ready held high.
    number_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int k = 3; k >= 0; k--) put(vec[i].digits[k*4 +: 4]);
      chk("check_cycle_valid", 16'(number_valid), 16'h0);
      chk("check_cycle_count", 16'(digit_count),  16'h4);
      @(negedge clock);
      chk("vec_valid",  16'(number_valid), 16'(vec[i].ok));
      chk("vec_reject", 16'(reject),       16'(!vec[i].ok));
      if (vec[i].ok) chk("vec_num", 16'(number_out), vec[i].digits);
      chk("nu_valid", 16'(nu_valid), 16'h1);
      chk("nu_num",   16'(nu_out),   vec[i].digits);
      chk("nu_reject",16'(nu_reject),16'h0);
      @(negedge clock);
      chk("post_valid",  16'(number_valid), 16'h0);
      chk("post_reject", 16'(reject),       16'h0);
      chk("post_count",  16'(digit_count),  16'h0);
      chk("nu_post_count", 16'(nu_count),   16'h0);
    end
    chk("table_xfers", 16'(xfers), 16'd3);

    // Out-of-range digit is refused without disturbing the entry.
    put(4'h1); put(4'h2); put(4'hA);
    chk("bad_digit_reject", 16'(reject),      16'h1);
    chk("bad_digit_count",  16'(digit_count), 16'h2);
    @(negedge clock);
    chk("bad_digit_pulse",  16'(reject),      16'h0);
    put(4'h8); put(4'h9);
    @(negedge clock);
    chk("after_bad_valid", 16'(number_valid), 16'h1);
    chk("after_bad_num",   16'(number_out),   16'h1289);
    @(negedge clock);

    // Backpressure: offer held stable, strobes ignored.
    number_ready = 1'b0;
    put(4'h9); put(4'h8); put(4'h7); put(4'h6);
    @(negedge clock);
    x0 = xfers;
    for (int c = 0; c < 10; c++) begin
      digit_in  = 4'(c);
      digit_stb = c[0];
      clear_stb = ~c[0];
      @(negedge clock);
      chk("hold_valid",  16'(number_valid), 16'h1);
      chk("hold_num",    16'(number_out),   16'h9876);
      chk("hold_count",  16'(digit_count),  16'h4);
      chk("hold_reject", 16'(reject),       16'h0);
    end
    digit_stb = 1'b0;
    clear_stb = 1'b0;
    number_ready = 1'b1;
    @(negedge clock);
    chk("release_valid", 16'(number_valid), 16'h0);
    chk("release_xfers", 16'(xfers - x0),   16'h1);
    @(negedge clock);
    chk("single_xfer",   16'(xfers - x0),   16'h1);

    // Clear beats a simultaneous digit.
    put(4'h3); put(4'h1);
    chk("pre_clear_count", 16'(digit_count), 16'h2);
    chk("partial_num",     16'(number_out),  16'h0031);
    digit_in = 4'h4; digit_stb = 1'b1; clear_stb = 1'b1;
    @(negedge clock);
    digit_stb = 1'b0; clear_stb = 1'b0;
    chk("clear_count", 16'(digit_count), 16'h0);
    chk("clear_num",   16'(number_out),  16'h0);
    chk("clear_reject",16'(reject),      16'h0);
    put(4'h4); put(4'h5); put(4'h6); put(4'h7);
    @(negedge clock);
    chk("after_clear_num",   16'(number_out),   16'h4567);
    chk("after_clear_valid", 16'(number_valid), 16'h1);
    @(negedge clock);

    // Async reset mid-entry.
    put(4'h1); put(4'h2); put(4'h3);
    #2 reset = 1'b0;
    #1;
    chk("rst_entry_count", 16'(digit_count), 16'h0);
    chk("rst_entry_num",   16'(number_out),  16'h0);
    @(negedge clock);
    reset = 1'b1;

    // Async reset mid-offer: no transfer completes.
    number_ready = 1'b0;
    put(4'h2); put(4'h4); put(4'h6); put(4'h8);
    @(negedge clock);
    chk("offer_valid", 16'(number_valid), 16'h1);
    x0 = xfers;
    #2 reset = 1'b0;
    #1;
    chk("rst_offer_valid", 16'(number_valid), 16'h0);
    chk("rst_offer_num",   16'(number_out),   16'h0);
    chk("rst_offer_count", 16'(digit_count),  16'h0);
    number_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_offer_xfers", 16'(xfers - x0),   16'h0);
    chk("rst_offer_idle",  16'(number_valid), 16'h0);

`ifdef BULLCOW_ENTRY_BACKSPACE_EN
    del_stb = 1'b1;
    @(negedge clock);
    del_stb = 1'b0;
    chk("del_empty_reject", 16'(reject),      16'h0);
    chk("del_empty_count",  16'(digit_count), 16'h0);
    put(4'h1); put(4'h2); put(4'h3);
    del_stb = 1'b1;
    @(negedge clock);
    del_stb = 1'b0;
    chk("del_count", 16'(digit_count), 16'h2);
    chk("del_num",   16'(number_out),  16'h0012);
    put(4'h4); put(4'h5);
    @(negedge clock);
    chk("del_final_valid", 16'(number_valid), 16'h1);
    chk("del_final_num",   16'(number_out),   16'h1245);
    @(negedge clock);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
